fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader.sv | 182 ++++++++++++++++++
 tb/tb_fifo_stream_reader.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops pixels from a show-ahead-free FIFO (data one cycle
// after r_en_o) into a 2-entry skid buffer and presents them as a valid/ready
// pixel stream with end-of-line / end-of-frame markers for one IMG_W x IMG_H frame.
// Optional feature: define FIFO_READER_STALL_CNT_EN to add stall_cnt_o, a
// saturating count of RUN cycles spent waiting on an empty FIFO.
//
// Stream handshake: a pixel transfers on every rising edge where
// m_valid_o & m_ready_i; while m_valid_o is high and m_ready_i is low, the
// word and its eol/eof flags are held unchanged until accepted.
module fifo_stream_reader #(
   parameter int DATA_WD = 16,
   parameter int IMG_W   = 640,
   parameter int IMG_H   = 480
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               empty_i,
   input  logic [DATA_WD-1:0] data_i,
   output logic               r_en_o,
   output logic [DATA_WD-1:0] m_data_o,
   output logic               m_valid_o,
   input  logic               m_ready_i,
   output logic               eol_o,
   output logic               eof_o,
   output logic               busy_o,
   output logic               done_o,
   output logic [1:0]         state_o
`ifdef FIFO_READER_STALL_CNT_EN
   ,
   output logic [15:0]        stall_cnt_o
`endif
);

   localparam int TOTAL = IMG_W * IMG_H;
   localparam int IW    = $clog2(TOTAL + 1);
   localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [IW-1:0] TOTAL_C  = IW'(TOTAL);
   localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [IW-1:0]      issued;
   logic [CW-1:0]      col;
   logic [RW-1:0]      row;
   logic [1:0]         occ;
   logic               in_flight;
   logic [DATA_WD-1:0] head_word;
   logic [DATA_WD-1:0] tail_word;
   logic               start_acc;
   logic               pop;
   logic               cap;
   logic               ren;
   logic [2:0]         room;

   // Handshake terms and pop gating: a pop is allowed only if the buffer can
   // still absorb every word already requested, counting this cycle's transfer.
   always_comb begin
      start_acc = 1'b0;
      pop       = 1'b0;
      cap       = 1'b0;
      room      = 3'd0;
      ren       = 1'b0;
      start_acc = (state == IDLE) && start_i;
      pop       = (occ != 2'd0) && m_ready_i;
      cap       = in_flight;
      room      = {1'b0, occ} + {2'b00, in_flight} - {2'b00, pop};
      ren       = (state == RUN) && !empty_i && (issued < TOTAL_C) && (room < 3'd2);
   end

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic: finish issuing, then wait for the buffer and the last read to clear.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_i) state_nxt = RUN;
         RUN:     if (issued == TOTAL_C) state_nxt = DRAIN;
         DRAIN:   if ((occ == 2'd0) && !in_flight) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Pop-request counter for the current frame, plus the one-deep read-in-flight flag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         issued    <= '0;
         in_flight <= 1'b0;
      end else begin
         in_flight <= ren;
         if (start_acc)  issued <= '0;
         else if (ren)   issued <= issued + IW'(1);
      end
   end

   // Two-entry output buffer; head is the word on the stream. A capture and a
   // transfer in the same cycle keep the occupancy constant.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         occ       <= 2'd0;
         head_word <= '0;
         tail_word <= '0;
      end else begin
         case ({cap, pop})
            2'b10: begin
               if (occ == 2'd0) head_word <= data_i;
               else             tail_word <= data_i;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               head_word <= tail_word;
               occ       <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  head_word <= data_i;
               end else begin
                  head_word <= tail_word;
                  tail_word <= data_i;
               end
            end
            default: ;
         endcase
      end
   end

   // Column/row position of the head pixel, advanced on each stream transfer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         col <= '0;
         row <= '0;
      end else if (start_acc) begin
         col <= '0;
         row <= '0;
      end else if (pop) begin
         if (col == LAST_COL) begin
            col <= '0;
            row <= (row == LAST_ROW) ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

`ifdef FIFO_READER_STALL_CNT_EN
   logic [15:0] stall_cnt;

   // Saturating count of RUN cycles with the FIFO empty; restarts with each frame.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                                                    stall_cnt <= 16'd0;
      else if (start_acc)                                           stall_cnt <= 16'd0;
      else if ((state == RUN) && empty_i && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
   end

   assign stall_cnt_o = stall_cnt;
`endif

   assign r_en_o    = ren;
   assign m_valid_o = (occ != 2'd0);
   assign m_data_o  = head_word;
   assign eol_o     = m_valid_o && (col == LAST_COL);
   assign eof_o     = eol_o && (row == LAST_ROW);
   assign busy_o    = (state != IDLE);
   assign done_o    = (state == DONE);
   assign state_o   = state;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader with a 4x2 frame: a simple FIFO model, a
// transfer monitor with an expected-word queue, and directed frame scenarios.
module tb_fifo_stream_reader;

   localparam int DW = 16;
   localparam int W  = 4;
   localparam int H  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          empty;
   logic [DW-1:0] fifo_data = '0;
   logic          r_en_o;
   logic [DW-1:0] m_data_o;
   logic          m_valid_o;
   logic          m_ready = 1'b0;
   logic          eol_o;
   logic          eof_o;
   logic          busy_o;
   logic          done_o;
   logic [1:0]    state_o;
`ifdef FIFO_READER_STALL_CNT_EN
   logic [15:0]   stall_cnt_o;
`endif

   int n_checks = 0;
   int n_errs   = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   fifo_stream_reader #(.DATA_WD(DW), .IMG_W(W), .IMG_H(H)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .start_i   (start),
      .empty_i   (empty),
      .data_i    (fifo_data),
      .r_en_o    (r_en_o),
      .m_data_o  (m_data_o),
      .m_valid_o (m_valid_o),
      .m_ready_i (m_ready),
      .eol_o     (eol_o),
      .eof_o     (eof_o),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .state_o   (state_o)
`ifdef FIFO_READER_STALL_CNT_EN
      ,
      .stall_cnt_o (stall_cnt_o)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- FIFO model ----------------
   logic [DW-1:0] fmem [0:63];
   int            wr_ptr = 0;
   int            rd_ptr = 0;
   logic          hold_empty = 1'b0;
   int            pop_total = 0;

   assign empty = hold_empty || (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (r_en_o) begin
         if (empty) check("pop_on_empty", 1, 0);
         fifo_data <= fmem[rd_ptr % 64];
         rd_ptr    <= rd_ptr + 1;
         pop_total <= pop_total + 1;
      end
   end

   // ---------------- scoreboard / monitor ----------------
   logic [17:0]   exp_q[$];
   logic [17:0]   mon_e;
   int            xfer_cnt = 0;
   int            last_xfer_cyc = 0;
   int            done_cycles = 0;
   int            done_cyc = 0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] held_data = '0;
   logic [1:0]    held_flags = '0;

   always @(negedge clk) begin
      #1;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("valid_hold", 32'(m_valid_o), 1);
            check("data_hold", 32'(m_data_o), 32'(held_data));
            check("flag_hold", 32'({eof_o, eol_o}), 32'(held_flags));
         end
         if (m_valid_o && m_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_xfer", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("xfer_data", 32'(m_data_o), 32'(mon_e[15:0]));
               check("xfer_eol", 32'(eol_o), 32'(mon_e[16]));
               check("xfer_eof", 32'(eof_o), 32'(mon_e[17]));
            end
            xfer_cnt++;
            last_xfer_cyc = cyc;
         end
         if (done_o) begin
            done_cycles++;
            done_cyc = cyc;
         end
         prev_stall = m_valid_o && !m_ready;
         held_data  = m_data_o;
         held_flags = {eof_o, eol_o};
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      wr_ptr = rd_ptr;
      exp_q.delete();
      hold_empty = 1'b0;
      start = 1'b0;
      m_ready = 1'b0;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic preload(input int base, input int n);
      for (int k = 0; k < n; k++) begin
         fmem[wr_ptr % 64] = 16'(base + k);
         wr_ptr++;
      end
   endtask

   // One 4x2 frame: eol on pixels 3 and 7, eof on pixel 7.
   task automatic expect_frame(input int base);
      logic [17:0] e;
      for (int k = 0; k < 8; k++) begin
         e = {(k == 7), ((k % 4) == 3), 16'(base + k)};
         exp_q.push_back(e);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_xfers(input int target, input int budget);
      for (int i = 0; i < budget && xfer_cnt < target; i++) @(negedge clk);
      check("xfer_timeout", 32'(xfer_cnt >= target), 1);
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #2;
         if (done_o) break;
      end
      check("done_seen", 32'(done_o), 1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ren"},   32'(r_en_o), 0);
      check({tag, "_valid"}, 32'(m_valid_o), 0);
      check({tag, "_data"},  32'(m_data_o), 0);
      check({tag, "_eol"},   32'(eol_o), 0);
      check({tag, "_eof"},   32'(eof_o), 0);
      check({tag, "_busy"},  32'(busy_o), 0);
      check({tag, "_done"},  32'(done_o), 0);
      check({tag, "_state"}, 32'(state_o), 0);
   endtask

   // ---------------- stimulus ----------------
   int xb, pb, db, first_cyc;

   initial begin
      // reset values
      rst = 1'b1;
      #2;
      check_all_zero("rst");
      do_reset();

      // full-rate frame 0x10..0x17
      preload(16'h10, 8);
      expect_frame(16'h10);
      m_ready = 1'b1;
      xb = xfer_cnt; pb = pop_total; db = done_cycles;
      pulse_start();
      #1;
      check("t1_busy", 32'(busy_o), 1);
      wait_xfers(xb + 1, 50);
      first_cyc = last_xfer_cyc;
      wait_done(50);
      check("t1_burst", 32'(last_xfer_cyc - first_cyc), 7);
      check("t1_done_lat", 32'(done_cyc - last_xfer_cyc), 2);
      @(negedge clk);
      #2;
      check("t1_done_pulse", 32'(done_o), 0);
      check("t1_idle", 32'(busy_o), 0);
      check("t1_left", 32'(exp_q.size()), 0);
      check("t1_pops", 32'(pop_total - pb), 8);
      check("t1_done_cnt", 32'(done_cycles - db), 1);

      // back-pressure: ready low 5 cycles mid-frame
      do_reset();
      preload(16'h20, 8);
      expect_frame(16'h20);
      m_ready = 1'b1;
      xb = xfer_cnt; pb = pop_total; db = done_cycles;
      pulse_start();
      wait_xfers(xb + 3, 50);
      m_ready = 1'b0;
      for (int s = 1; s <= 5; s++) begin
         #1;
         if (s >= 2) check("t2_ren_stop", 32'(r_en_o), 0);
         check("t2_valid", 32'(m_valid_o), 1);
         @(negedge clk);
      end
      m_ready = 1'b1;
      wait_done(60);
      check("t2_left", 32'(exp_q.size()), 0);
      check("t2_pops", 32'(pop_total - pb), 8);
      check("t2_done_cnt", 32'(done_cycles - db), 1);

      // FIFO empty 3 cycles mid-frame (one spare word keeps it non-empty at frame end)
      do_reset();
      preload(16'h30, 9);
      expect_frame(16'h30);
      m_ready = 1'b1;
      xb = xfer_cnt; pb = pop_total;
      pulse_start();
      wait_xfers(xb + 3, 50);
      hold_empty = 1'b1;
      for (int s = 1; s <= 3; s++) begin
         #1;
         check("t3_ren_empty", 32'(r_en_o), 0);
         if (s == 3) check("t3_drained", 32'(m_valid_o), 0);
         @(negedge clk);
      end
      hold_empty = 1'b0;
      wait_done(60);
      check("t3_left", 32'(exp_q.size()), 0);
      check("t3_pops", 32'(pop_total - pb), 8);
`ifdef FIFO_READER_STALL_CNT_EN
      check("t3_stall_cnt", 32'(stall_cnt_o), 3);
`endif

      // reset after 3 transfers, then a clean frame
      do_reset();
      preload(16'h40, 8);
      expect_frame(16'h40);
      m_ready = 1'b1;
      xb = xfer_cnt;
      pulse_start();
      wait_xfers(xb + 3, 50);
      rst = 1'b1;
      #1;
      check_all_zero("t4_rst");
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      wr_ptr = rd_ptr;
      rst = 1'b0;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         #2;
         check("t4_no_stale", 32'(m_valid_o), 0);
      end
      preload(16'h50, 8);
      expect_frame(16'h50);
      pb = pop_total;
      @(negedge clk);
      pulse_start();
      wait_done(60);
      check("t4_left", 32'(exp_q.size()), 0);
      check("t4_pops", 32'(pop_total - pb), 8);

      // start during RUN is ignored
      do_reset();
      preload(16'h60, 8);
      expect_frame(16'h60);
      m_ready = 1'b1;
      xb = xfer_cnt; pb = pop_total; db = done_cycles;
      pulse_start();
      wait_xfers(xb + 2, 50);
      pulse_start();
      wait_done(60);
      for (int s = 0; s < 5; s++) @(negedge clk);
      #2;
      check("t5_idle", 32'(busy_o), 0);
      check("t5_state", 32'(state_o), 0);
      check("t5_left", 32'(exp_q.size()), 0);
      check("t5_pops", 32'(pop_total - pb), 8);
      check("t5_done_cnt", 32'(done_cycles - db), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
      $finish;
   end

   // watchdog
   initial begin
      #200000;
      check("watchdog", 0, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
      $finish;
   end

endmodule
